// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM stage: access sizes, exception codes,
// EX control-bundle bit positions and the stage FSM state type.
package mem_access_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   localparam logic [1:0] EXC_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
   localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

   localparam int unsigned CTRL_W       = 8;
   localparam int unsigned CTRL_RES_SEL = 7;
   localparam int unsigned CTRL_SIGNED  = 6;
   localparam int unsigned CTRL_SIZE_HI = 5;
   localparam int unsigned CTRL_SIZE_LO = 4;
   localparam int unsigned CTRL_WRITE   = 3;
   localparam int unsigned CTRL_READ    = 2;
   localparam int unsigned CTRL_WB_HI   = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Number of bytes touched by an access of the given size code.
   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte-enables and lane replication,
// load lane extraction with sign/zero extension.
module mem_lane_align
   import mem_access_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [1:0]                   i_st_size,
   input  logic [$clog2(DATA_W/8)-1:0]  i_st_off,
   input  logic [DATA_W-1:0]            i_st_data,
   output logic [DATA_W/8-1:0]          o_be_c,
   output logic [DATA_W-1:0]            o_wdata_c,
   input  logic [1:0]                   i_ld_size,
   input  logic [$clog2(DATA_W/8)-1:0]  i_ld_off,
   input  logic                         i_ld_signed,
   input  logic [DATA_W-1:0]            i_rdata,
   output logic [DATA_W-1:0]            o_ld_data_c
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);

   // Round a lane offset down to the natural alignment of the access size.
   function automatic logic [OFF_W-1:0] align_off(input logic [OFF_W-1:0] off,
                                                   input logic [1:0] size);
      return off & ~OFF_W'(size_bytes(size) - 4'd1);
   endfunction

   logic [OFF_W-1:0]  w_st_off;
   logic [OFF_W-1:0]  w_ld_off;
   logic [7:0]        w_size_mask;
   logic [DATA_W-1:0] w_ld_sh;
   logic [DATA_W-1:0] w_keep;
   logic [6:0]        w_nbits;
   logic              w_sign;

   assign w_st_off    = align_off(i_st_off, i_st_size);
   assign w_size_mask = 8'((9'd1 << size_bytes(i_st_size)) - 9'd1);
   assign o_be_c      = BE_W'(w_size_mask) << w_st_off;

   always_comb begin
      o_wdata_c = i_st_data;
      case (i_st_size)
         SZ_B:    o_wdata_c = {(DATA_W/8){i_st_data[7:0]}};
         SZ_H:    o_wdata_c = {(DATA_W/16){i_st_data[15:0]}};
         SZ_W:    o_wdata_c = {(DATA_W/32){i_st_data[31:0]}};
         default: o_wdata_c = i_st_data;
      endcase
   end

   assign w_ld_off = align_off(i_ld_off, i_ld_size);
   assign w_ld_sh  = i_rdata >> {w_ld_off, 3'b000};
   assign w_nbits  = {size_bytes(i_ld_size), 3'b000};
   // Shifting past DATA_W yields zero, so a full-width access keeps every bit.
   assign w_keep   = ~({DATA_W{1'b1}} << w_nbits);

   always_comb begin
      w_sign = 1'b0;
      case (i_ld_size)
         SZ_B:    w_sign = w_ld_sh[7];
         SZ_H:    w_sign = w_ld_sh[15];
         SZ_W:    w_sign = w_ld_sh[31];
         default: w_sign = w_ld_sh[DATA_W-1];
      endcase
   end

   assign o_ld_data_c = (w_ld_sh & w_keep) | (~w_keep & {DATA_W{w_sign & i_ld_signed}});

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: registers the EX bundle, runs variable-latency bus accesses
// and reports precise exceptions. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses.
module mem_access_stage
   import mem_access_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_W   = 5,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ex_valid_in,
   output logic                 ex_ready_out,
   input  logic [CTRL_W-1:0]    ex_ctrl_in,
   input  logic [ADDR_W-1:0]    ex_addr_in,
   input  logic [DATA_W-1:0]    ex_store_data_in,
   input  logic [REG_W-1:0]     ex_write_reg_in,
   input  logic [ADDR_W-1:0]    ex_pc_seq_in,
   output logic                 wb_valid_out,
   output logic [DATA_W-1:0]    wb_result_out,
   output logic [REG_W-1:0]     wb_write_reg_out,
   output logic [ADDR_W-1:0]    wb_pc_seq_out,
   output logic [1:0]           wb_ctrl_out,
   output logic                 mem_req_out,
   output logic                 mem_we_out,
   output logic [ADDR_W-1:0]    mem_addr_out,
   output logic [DATA_W/8-1:0]  mem_be_out,
   output logic [DATA_W-1:0]    mem_wdata_out,
   input  logic                 mem_ack_in,
   input  logic [DATA_W-1:0]    mem_rdata_in,
   output logic                 exc_valid_out,
   output logic [1:0]           exc_code_out,
   output logic [ADDR_W-1:0]    exc_addr_out
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(BE_W);
   localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]        w_size;
   logic              w_rd;
   logic              w_wr;
   logic              w_illegal;
   logic              w_misal;
   logic [BE_W-1:0]   w_be;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_ld_data;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic              r_rd;
   logic              r_res_sel;
   logic              r_signed;

   assign w_size    = ex_ctrl_in[CTRL_SIZE_HI:CTRL_SIZE_LO];
   assign w_rd      = ex_ctrl_in[CTRL_READ];
   assign w_wr      = ex_ctrl_in[CTRL_WRITE];
   assign w_illegal = (w_rd && w_wr) || ((w_size == SZ_D) && (DATA_W == 32));

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misal = (ex_addr_in[OFF_W-1:0] & OFF_W'(size_bytes(w_size) - 4'd1)) != '0;
`else
   assign w_misal = 1'b0;
`endif

   mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
      .i_st_size   (w_size),
      .i_st_off    (ex_addr_in[OFF_W-1:0]),
      .i_st_data   (ex_store_data_in),
      .o_be_c      (w_be),
      .o_wdata_c   (w_wdata),
      .i_ld_size   (r_size),
      .i_ld_off    (r_addr[OFF_W-1:0]),
      .i_ld_signed (r_signed),
      .i_rdata     (mem_rdata_in),
      .o_ld_data_c (w_ld_data)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state          <= ST_IDLE;
         r_cnt            <= '0;
         r_addr           <= '0;
         r_size           <= SZ_B;
         r_rd             <= 1'b0;
         r_res_sel        <= 1'b0;
         r_signed         <= 1'b0;
         ex_ready_out     <= 1'b0;
         wb_valid_out     <= 1'b0;
         wb_result_out    <= '0;
         wb_write_reg_out <= '0;
         wb_pc_seq_out    <= '0;
         wb_ctrl_out      <= '0;
         mem_req_out      <= 1'b0;
         mem_we_out       <= 1'b0;
         mem_addr_out     <= '0;
         mem_be_out       <= '0;
         mem_wdata_out    <= '0;
         exc_valid_out    <= 1'b0;
         exc_code_out     <= '0;
         exc_addr_out     <= '0;
      end else begin
         wb_valid_out  <= 1'b0;
         exc_valid_out <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               ex_ready_out <= 1'b1;
               if (ex_valid_in && ex_ready_out) begin
                  r_addr           <= ex_addr_in;
                  r_size           <= w_size;
                  r_rd             <= w_rd;
                  r_res_sel        <= ex_ctrl_in[CTRL_RES_SEL];
                  r_signed         <= ex_ctrl_in[CTRL_SIGNED];
                  wb_write_reg_out <= ex_write_reg_in;
                  wb_pc_seq_out    <= ex_pc_seq_in;
                  wb_ctrl_out      <= ex_ctrl_in[CTRL_WB_HI:0];
                  exc_addr_out     <= ex_addr_in;
                  if (w_illegal) begin
                     exc_valid_out <= 1'b1;
                     exc_code_out  <= EXC_ILLEGAL;
                  end else if ((w_rd || w_wr) && w_misal) begin
                     exc_valid_out <= 1'b1;
                     exc_code_out  <= EXC_MISALIGN;
                  end else if (w_rd || w_wr) begin
                     r_state       <= ST_WAIT;
                     r_cnt         <= '0;
                     ex_ready_out  <= 1'b0;
                     mem_req_out   <= 1'b1;
                     mem_we_out    <= w_wr;
                     mem_addr_out  <= {ex_addr_in[ADDR_W-1:OFF_W], OFF_W'(0)};
                     mem_be_out    <= w_be;
                     mem_wdata_out <= w_wr ? w_wdata : '0;
                  end else begin
                     wb_valid_out  <= 1'b1;
                     wb_result_out <= DATA_W'(ex_addr_in);
                  end
               end
            end
            ST_WAIT: begin
               // An ack arriving in the expiry cycle still completes the access.
               if (mem_ack_in) begin
                  r_state       <= ST_IDLE;
                  ex_ready_out  <= 1'b1;
                  mem_req_out   <= 1'b0;
                  wb_valid_out  <= 1'b1;
                  wb_result_out <= (r_rd && r_res_sel) ? w_ld_data : DATA_W'(r_addr);
               end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
                  r_state       <= ST_IDLE;
                  ex_ready_out  <= 1'b1;
                  mem_req_out   <= 1'b0;
                  exc_valid_out <= 1'b1;
                  exc_code_out  <= EXC_TIMEOUT;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised MEM pipeline stage for the MIPS core: registers the EX-stage bundle, issues byte-lane-correct loads and stores to a variable-latency data-memory bus, and sign/zero-extends load results. It stalls EX while a bus access is outstanding and raises precise exceptions for bad control, timeouts and (optionally) misalignment. It sits between the EX stage and the write-back mux, replacing the fixed single-cycle memory stage.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, bus/register width; 32 or 64.
- REG_W, 5, destination register index width.
- TIMEOUT, 255, max WAIT cycles before bus error; 0 disables the timeout.

- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- ex_valid_in  in  1  EX presents an instruction.
- ex_ready_out  out  1  stage can capture this cycle.
- ex_ctrl_in  in  8  bundle: [7] result select (1 = memory data), [6] signed, [5:4] size (00 B, 01 H, 10 W, 11 D), [3] write, [2] read, [1:0] WB controls.
- ex_addr_in  in  ADDR_W  ALU result / effective address.
- ex_store_data_in  in  DATA_W  register B.
- ex_write_reg_in  in  REG_W  destination register.
- ex_pc_seq_in  in  ADDR_W  PC+4.
- wb_valid_out  out  1  one-cycle result strobe.
- wb_result_out  out  DATA_W  address or extended load data.
- wb_write_reg_out  out  REG_W  destination register.
- wb_pc_seq_out  out  ADDR_W  PC+4.
- wb_ctrl_out  out  2  bundle [1:0].
- mem_req_out  out  1  bus request, held until ack.
- mem_we_out  out  1  1 = store.
- mem_addr_out  out  ADDR_W  address, low log2(DATA_W/8) bits zero.
- mem_be_out  out  DATA_W/8  byte enables.
- mem_wdata_out  out  DATA_W  lane-replicated store data.
- mem_ack_in  in  1  access complete.
- mem_rdata_in  in  DATA_W  read data, valid with ack.
- exc_valid_out  out  1  one-cycle exception strobe.
- exc_code_out  out  2  01 misaligned, 10 bus timeout, 11 illegal control.
- exc_addr_out  out  ADDR_W  faulting address.

## Operation
- FSM states:
  - IDLE: ex_ready_out = 1.
  - WAIT: request outstanding; ex_ready_out = 0.
- Capture happens when ex_valid_in && ex_ready_out; all ex_* inputs are registered.
- Non-memory op (read = write = 0): next cycle wb_valid_out = 1 with wb_result_out = captured address; stay IDLE.
- Illegal control (read && write, or size 11 when DATA_W = 32): next cycle exc_valid_out, code 11; no request; no wb_valid_out.
- Memory op: go to WAIT. mem_req_out is held with constant addr/we/be/wdata until mem_ack_in is sampled high.
- On ack: load or store completes; wb_valid_out pulses next cycle (stores too, with result = address); return to IDLE.
- Load data:
  - Lane selected by address offset.
  - Extension by [6]: signed = sign-extend, else zero-extend to DATA_W.
  - Result is rdata when [7] = 1, else address.
- Store data:
  - be = size mask (1/3/F/FF) shifted left by offset.
  - wdata = B replicated across lanes.
- Timeout: counter clears on entry to WAIT and increments each WAIT cycle. At TIMEOUT with no ack: drop mem_req_out, exc code 10, return to IDLE, no wb_valid_out. An ack in the same cycle as expiry wins.
- Reset low: all outputs 0, FSM IDLE, counter 0. Reset during WAIT abandons the request; mem_req_out is 0 the cycle after.

## Timing
- Non-memory ops: capture at edge N, wb_valid_out high during cycle N+1. Back-to-back throughput is one per cycle.
- Memory ops: mem_req_out high from cycle N+1. An ack sampled at edge M gives wb_valid_out and ex_ready_out high during cycle M+1.
- Minimum memory-op latency: 2 cycles (ack in the first request cycle).
- All outputs are registered; no combinational path from mem_ack_in to ex_ready_out.
- wb_valid_out and exc_valid_out are never both high.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A half access with addr[0] ≠ 0, a word access with addr[1:0] ≠ 0, or a double access with addr[2:0] ≠ 0 raises exc code 01 in cycle N+1.
  - No request is issued.
- MEM_ALIGN_CHECK_EN undefined: the offset is rounded down to natural alignment for that size; no exception.

## Structure
- Package mem_access_pkg:
  - size encodings, exception codes, bundle bit-position constants;
  - FSM state typedef.
- Sub-module mem_lane_align (combinational): load lane select plus extension, store byte-enable plus replication; parametrised by DATA_W.

## Test plan
- Non-mem op, addr 0x0000_1234 → wb_valid_out one cycle later, result 0x0000_1234, no mem_req_out.
- Signed byte load at 0x103, rdata 0x80FF_FF7F, ack after 3 cycles → result 0xFFFF_FF80; wb_valid_out 1 cycle after ack; ex_ready_out low for 4 cycles.
- Half store of 0x0000_ABCD at 0x202 → mem_be_out 4'b1100, wdata 0xABCD_ABCD, mem_addr_out 0x200.
- No ack, TIMEOUT = 4 → mem_req_out drops after 4 WAIT cycles, exc code 10, exc_addr = request address.
- Word load at 0x101 with MEM_ALIGN_CHECK_EN → exc code 01, no request. Without the macro → access at 0x100.
- reset low during WAIT → all outputs 0 next cycle; after release, a non-mem op completes normally.
